fetch_prefetch: RTL and testbench
=================================

# fetch_prefetch

Parametrised fetch front end that decouples instruction-cache latency from decode. It runs a fetch PC, issues one blocking read at a time to the instruction memory system (Rd/Done/Stall/err protocol), and buffers returned instructions with their incremented PC in a DEPTH-entry queue. The queue drains to decode over a valid/ready handshake. On a redirect (jump or branch misprediction) it flushes the queue and discards any in-flight response. It sits between the PC redirect logic and the fetch/decode pipeline register.

## Interface
- INST_W, 16, instruction width
- ADDR_W, 16, PC/address width
- DEPTH, 4, queue entries (power of two, ≥2)
- PC_INC, 2, PC increment per instruction
- RESET_PC, 0, fetch PC after reset
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- redirect  in  1  jump/misprediction; load redirect_pc, flush
- redirect_pc  in  ADDR_W  new fetch target
- mem_addr  out  ADDR_W  read address, stable while mem_rd=1
- mem_rd  out  1  read request
- mem_done  in  1  read complete, mem_data valid this cycle
- mem_stall  in  1  memory busy (informational; no new issue while high)
- mem_data  in  INST_W  returned instruction
- mem_err  in  1  memory error
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head
- out_inst  out  INST_W  head instruction; NOP 16'h0800 when !out_valid
- out_pc_inc  out  ADDR_W  head PC + PC_INC
- err  out  1  sticky fetch error

## Operation
- FSM states: IDLE, REQ, DROP, HALT.
- IDLE: if room (count + pops ≤ DEPTH-1 after this edge) and !mem_stall → REQ with req_addr ← fetch_pc.
- REQ: mem_rd=1, mem_addr=req_addr. On mem_done: push {mem_data, req_addr+PC_INC}; fetch_pc ← req_addr+PC_INC; if room remains → stay REQ with req_addr ← new fetch_pc, else → IDLE.
- DROP: mem_rd=1 on the old req_addr until mem_done; the response is discarded. Then → IDLE.
- HALT: mem_rd=0. No issue. Queue still drains. Exits only on rst.
- Issue gating: count + (outstanding ? 1 : 0) < DEPTH. The queue therefore never overflows.
- Redirect has priority over push, pop and issue:
  - count ← 0, fetch_pc ← redirect_pc.
  - From REQ without same-cycle mem_done → DROP.
  - From REQ with same-cycle mem_done → data discarded, → IDLE.
  - From DROP → stay DROP; fetch_pc updated (last redirect wins).
  - From IDLE → stays IDLE; issues next cycle from redirect_pc.
- Pop: out_valid & out_ready & !redirect. Push and pop in the same cycle keep count unchanged.
- mem_err high while mem_rd=1 → HALT and err ← 1. Any returned data is discarded.
- Address arithmetic is modulo 2^ADDR_W; wrap from 16'hFFFE to 16'h0000 is legal.

## Timing
- Reset values: state IDLE, fetch_pc=RESET_PC, count 0, out_valid 0, out_inst 16'h0800, out_pc_inc 0, mem_rd 0, err 0.
- All outputs are registered or derived from queue/FSM state only. There are no combinational paths from the mem_* inputs to the out_* outputs, except under FETCH_BYPASS_EN.
- First request: mem_rd rises 1 cycle after rst deasserts.
- Data timing: mem_done at edge N → entry visible on out_valid at N+1.
- Throughput: 1 instruction/cycle when the memory returns mem_done every cycle and decode keeps out_ready high.
- Redirect at edge N → out_valid=0 from N+1 until the first post-redirect response.
- rst asserted mid-request: immediate return to reset values. The memory side is reset by the same rst.

## Configuration
- FETCH_BYPASS_EN defined:
  - When count==0, state REQ, mem_done=1, !redirect and out_ready=1, mem_data drives out_inst/out_valid combinationally in the same cycle and is not written to the queue.
  - If out_ready=0 in that situation, the data is pushed normally.
- Undefined: every response passes through the queue; minimum latency is 1 cycle.

## Structure
- Package fetch_pkg holds:
  - state enum (IDLE/REQ/DROP/HALT)
  - FETCH_NOP = 16'h0800
  - the queue entry struct {inst, pc_inc}
- Sub-module fetch_fifo: parametrised circular buffer (DEPTH, entry width) with push, pop, flush, count, and wrap-around read/write pointers. It uses the same clk/rst.

## Test plan
- Reset, memory returns mem_done every cycle with data 16'h1111, 16'h2222… and out_ready=1 → out_pc_inc 0x0002, 0x0004…; one instruction/cycle.
- out_ready=0 with DEPTH=4 → exactly 4 entries accepted, then mem_rd=0. Release out_ready → instructions drain in order, and fetching resumes when count drops to 3.
- Redirect to 0x0040 while REQ is waiting (mem_done delayed 3 cycles) → state DROP; the old response is discarded; the next mem_addr is 0x0040 and the first out_pc_inc is 0x0042.
- Redirect and mem_done in the same cycle with 2 queued entries → count 0, data dropped, next issue from redirect_pc.
- mem_err pulse during REQ → err=1 is sticky, mem_rd=0, and queued entries still drain. Only rst clears err.
- fetch_pc=16'hFFFE, mem_done → out_pc_inc 16'h0000 and the next mem_addr is 16'h0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch front end
package fetch_pkg;

    localparam int FETCH_INST_W = 16;
    localparam int FETCH_ADDR_W = 16;
    localparam logic [15:0] FETCH_NOP = 16'h0800;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        HALT = 2'd3
    } fetchState_t;

    // Default-width queue entry; fetch_prefetch declares a parameter-width twin.
    typedef struct packed {
        logic [FETCH_INST_W-1:0] inst;
        logic [FETCH_ADDR_W-1:0] pcInc;
    } fetchEntry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular buffer with push, pop, flush and occupancy count
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               pushData,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic [W-1:0]               headData
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) store[wrPtr] <= pushData;
    end

    assign headData = store[rdPtr];

endmodule

// File: rtl/fetch_prefetch.sv
// rtl/fetch_prefetch.sv - fetch PC, blocking imem reads, prefetch queue to decode (optional FETCH_BYPASS_EN)
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int                INST_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter int                PC_INC   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_done,
    input  logic              mem_stall,
    input  logic [INST_W-1:0] mem_data,
    input  logic              mem_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc_inc,
    output logic              err
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pcInc;
    } entry_t;

    fetchState_t       state, stateNext;
    logic [ADDR_W-1:0] fetchPc, fetchPcNext;
    logic [ADDR_W-1:0] reqAddr, reqAddrNext;
    logic              errNext;
    logic              push, pop, flush, bypass, qValid;
    logic [CW-1:0]     count, countAfterPop;
    logic [ADDR_W-1:0] doneAddr;
    entry_t            pushEntry, headEntry;

    fetch_fifo #(.DEPTH(DEPTH), .W(INST_W + ADDR_W)) uFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pushData (pushEntry),
        .pop      (pop),
        .flush    (flush),
        .count    (count),
        .headData (headEntry)
    );

    assign qValid        = (count != '0);
    assign pop           = qValid & out_ready & ~redirect;
    assign countAfterPop = count - CW'(pop);
    assign doneAddr      = reqAddr + ADDR_W'(PC_INC);
    assign pushEntry     = '{inst: mem_data, pcInc: doneAddr};

`ifdef FETCH_BYPASS_EN
    // Empty queue and a ready decoder: hand the response straight through.
    assign bypass = (count == '0) && (state == REQ) && mem_done && !mem_err
                    && !redirect && out_ready;
`else
    assign bypass = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            fetchPc <= RESET_PC;
            reqAddr <= RESET_PC;
            err     <= 1'b0;
        end else begin
            state   <= stateNext;
            fetchPc <= fetchPcNext;
            reqAddr <= reqAddrNext;
            err     <= errNext;
        end
    end

    always_comb begin
        stateNext   = state;
        fetchPcNext = fetchPc;
        reqAddrNext = reqAddr;
        errNext     = err;
        push        = 1'b0;
        flush       = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect && (countAfterPop < CW'(DEPTH)) && !mem_stall) begin
                    stateNext   = REQ;
                    reqAddrNext = fetchPc;
                end
            end
            REQ: begin
                if (mem_err) begin
                    stateNext = HALT;
                    errNext   = 1'b1;
                end else if (redirect) begin
                    stateNext = mem_done ? IDLE : DROP;
                end else if (mem_done) begin
                    push        = ~bypass;
                    fetchPcNext = doneAddr;
                    // Keep issuing only while the outstanding read is guaranteed a slot.
                    if ((countAfterPop + CW'(push)) < CW'(DEPTH)) begin
                        reqAddrNext = doneAddr;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            DROP: begin
                if (mem_err) begin
                    stateNext = HALT;
                    errNext   = 1'b1;
                end else if (mem_done) begin
                    stateNext = IDLE;
                end
            end
            default: ;
        endcase
        if (redirect) begin
            flush       = 1'b1;
            fetchPcNext = redirect_pc;
        end
    end

    assign mem_rd     = (state == REQ) || (state == DROP);
    assign mem_addr   = reqAddr;
    assign out_valid  = qValid | bypass;
    assign out_inst   = qValid ? headEntry.inst :
                        bypass ? mem_data : INST_W'(FETCH_NOP);
    assign out_pc_inc = qValid ? headEntry.pcInc :
                        bypass ? doneAddr : '0;

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb/tb_fetch_prefetch.sv - directed self-checking bench for fetch_prefetch
module tb_fetch_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_done;
    logic        mem_stall;
    logic [15:0] mem_data;
    logic        mem_err;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic [15:0] out_pc_inc;
    logic        err;

    int nCompared = 0;
    int nMismatched = 0;

    fetch_prefetch #(
        .INST_W(16), .ADDR_W(16), .DEPTH(4), .PC_INC(2), .RESET_PC(16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_done    (mem_done),
        .mem_stall   (mem_stall),
        .mem_data    (mem_data),
        .mem_err     (mem_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc_inc  (out_pc_inc),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; mem_done = 1'b0;
        mem_stall = 1'b0; mem_data = '0; mem_err = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_valid", 32'(out_valid), 0);
        checkVal("rst_inst", 32'(out_inst), 32'h0800);
        checkVal("rst_pcinc", 32'(out_pc_inc), 0);
        checkVal("rst_rd", 32'(mem_rd), 0);
        checkVal("rst_err", 32'(err), 0);
        rst = 1'b0;

        tick();
        checkVal("first_rd", 32'(mem_rd), 1);
        checkVal("first_addr", 32'(mem_addr), 0);

        // streaming: one instruction per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkVal("stream_addr", 32'(mem_addr), 32'(2 * i));
            d = 16'h1111 * 16'(i + 1);
            mem_done = 1'b1; mem_data = d;
            tick();
            checkVal("stream_valid", 32'(out_valid), 1);
            checkVal("stream_inst", 32'(out_inst), 32'(d));
            checkVal("stream_pcinc", 32'(out_pc_inc), 32'(2 * (i + 1)));
        end
        mem_done = 1'b0;
        tick();
        checkVal("drain_empty", 32'(out_valid), 0);
        checkVal("drain_addr", 32'(mem_addr), 32'h8);

        // fill with decode stalled
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_done = 1'b1; mem_data = 16'hA000 + 16'(k);
            tick();
            checkVal("fill_rd", 32'(mem_rd), (k < 3) ? 1 : 0);
        end
        mem_done = 1'b0;
        tick();
        tick();
        checkVal("full_rd", 32'(mem_rd), 0);
        checkVal("full_head", 32'(out_inst), 32'hA000);
        checkVal("full_pcinc", 32'(out_pc_inc), 32'hA);
        out_ready = 1'b1;
        tick();
        checkVal("resume_inst", 32'(out_inst), 32'hA001);
        checkVal("resume_rd", 32'(mem_rd), 1);
        checkVal("resume_addr", 32'(mem_addr), 32'h10);
        tick();
        checkVal("order2", 32'(out_inst), 32'hA002);
        tick();
        checkVal("order3", 32'(out_inst), 32'hA003);
        checkVal("order3_pc", 32'(out_pc_inc), 32'h10);
        tick();
        checkVal("order_empty", 32'(out_valid), 0);

        // redirect while a read is outstanding
        tick();
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        checkVal("drop_rd", 32'(mem_rd), 1);
        checkVal("drop_addr", 32'(mem_addr), 32'h10);
        tick();
        tick();
        mem_done = 1'b1; mem_data = 16'hDEAD;
        tick();
        mem_done = 1'b0;
        checkVal("drop_discard", 32'(out_valid), 0);
        checkVal("drop_idle_rd", 32'(mem_rd), 0);
        tick();
        checkVal("redir_addr", 32'(mem_addr), 32'h40);
        checkVal("redir_rd", 32'(mem_rd), 1);
        out_ready = 1'b0;
        mem_done = 1'b1; mem_data = 16'h4444;
        tick();
        checkVal("redir_inst", 32'(out_inst), 32'h4444);
        checkVal("redir_pcinc", 32'(out_pc_inc), 32'h42);

        // redirect coinciding with a response, two entries queued
        mem_data = 16'h5555;
        tick();
        checkVal("two_q_addr", 32'(mem_addr), 32'h44);
        mem_data = 16'h6666; redirect = 1'b1; redirect_pc = 16'h0080;
        tick();
        redirect = 1'b0; mem_done = 1'b0;
        checkVal("same_valid", 32'(out_valid), 0);
        checkVal("same_inst", 32'(out_inst), 32'h0800);
        checkVal("same_rd", 32'(mem_rd), 0);
        tick();
        checkVal("same_next_addr", 32'(mem_addr), 32'h80);

        // address wrap
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        tick();
        checkVal("wrap_addr", 32'(mem_addr), 32'hFFFE);
        mem_done = 1'b1; mem_data = 16'h7777;
        tick();
        checkVal("wrap_pcinc", 32'(out_pc_inc), 32'h0000);
        checkVal("wrap_next_addr", 32'(mem_addr), 32'h0000);
        mem_data = 16'h8888;
        tick();
        mem_done = 1'b0;

        // memory error halts fetch, queue still drains
        mem_err = 1'b1;
        tick();
        mem_err = 1'b0;
        checkVal("err_set", 32'(err), 1);
        checkVal("err_rd", 32'(mem_rd), 0);
        checkVal("err_head", 32'(out_inst), 32'h7777);
        out_ready = 1'b1;
        tick();
        checkVal("err_drain", 32'(out_inst), 32'h8888);
        checkVal("err_drain_pc", 32'(out_pc_inc), 32'h0002);
        tick();
        checkVal("err_empty", 32'(out_valid), 0);
        checkVal("err_empty_pc", 32'(out_pc_inc), 0);
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        tick();
        checkVal("halt_rd", 32'(mem_rd), 0);
        checkVal("err_sticky", 32'(err), 1);

        rst = 1'b1;
        #1;
        checkVal("async_rst_err", 32'(err), 0);
        checkVal("async_rst_rd", 32'(mem_rd), 0);
        rst = 1'b0;
        tick();
        checkVal("post_rst_rd", 32'(mem_rd), 1);
        checkVal("post_rst_addr", 32'(mem_addr), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
